dma_line_sched: RTL and testbench

- Sequences line-scan DMA writes into a ring of DDR buffers.
- Each sensor line_start becomes one write command to the DMA write master.
- Tracks buffer and line position and publishes the packed 29-bit dma_indexes status word.
- That status word feeds the HPS-readable Avalon-MM status register.

---
 rtl/dma_line_sched_pkg.sv | 26 ++
 rtl/dma_ring_ptr.sv | 71 +++++++
 rtl/dma_line_sched.sv | 177 +++++++++++++++++
 tb/tb_dma_line_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_line_sched_pkg.sv
// dma_line_sched_pkg: shared types and default widths for the line-scan DMA scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package dma_line_sched_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int LEN_W_DEF   = 16;
  localparam int LINE_W_DEF  = 12;
  localparam int BUF_W_DEF   = 4;
  localparam int FRAME_W_DEF = 13;
  localparam int IDX_W       = FRAME_W_DEF + BUF_W_DEF + LINE_W_DEF;  // 29-bit status word

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

  // Layout of the dma_indexes status word, MSB first.
  typedef struct packed {
    logic [FRAME_W_DEF-1:0] frame_cnt;
    logic [BUF_W_DEF-1:0]   buf_idx;
    logic [LINE_W_DEF-1:0]  line_idx;
  } dma_idx_t;

endpackage

// File: rtl/dma_ring_ptr.sv
// dma_ring_ptr: line/buffer/frame position and accumulating DDR address for a buffer ring.
// Latency: position updates on the edge where advance is high; init wins over advance.
// Backpressure: none; advance is a single-cycle strobe from the scheduler.
// Ports: clk/rst, init (restart at base_addr), advance (one line completed),
//        ring geometry inputs, position outputs, last_line (current line ends its buffer).
module dma_ring_ptr #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int LINE_W  = 12,
  parameter int BUF_W   = 4,
  parameter int FRAME_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               advance,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   line_bytes,
  input  logic [LINE_W-1:0]  lines_per_buf,
  input  logic [BUF_W-1:0]   num_bufs,
  output logic [LINE_W-1:0]  line_idx,
  output logic [BUF_W-1:0]   buf_idx,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               last_line
);

  logic [LINE_W-1:0] last_line_idx;
  logic [BUF_W-1:0]  last_buf_idx;
  logic              last_buf;
  logic [ADDR_W-1:0] step;

  // A zero count behaves like a count of one, so the last index is 0 in both cases.
  assign last_line_idx = (lines_per_buf == '0) ? '0 : lines_per_buf - LINE_W'(1);
  assign last_buf_idx  = (num_bufs == '0) ? '0 : num_bufs - BUF_W'(1);

  // >= rather than == so a geometry change under our feet still terminates the buffer.
  assign last_line = (line_idx >= last_line_idx);
  assign last_buf  = (buf_idx >= last_buf_idx);
  assign step      = {{(ADDR_W-LEN_W){1'b0}}, line_bytes};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_idx  <= '0;
      buf_idx   <= '0;
      frame_cnt <= '0;
      cur_addr  <= '0;
    end else if (init) begin
      line_idx  <= '0;
      buf_idx   <= '0;
      frame_cnt <= '0;
      cur_addr  <= base_addr;
    end else if (advance) begin
      if (!last_line) begin
        line_idx <= line_idx + LINE_W'(1);
        cur_addr <= cur_addr + step;
      end else begin
        line_idx  <= '0;
        frame_cnt <= frame_cnt + FRAME_W'(1);
        if (last_buf) begin
          buf_idx  <= '0;
          cur_addr <= base_addr;
        end else begin
          buf_idx  <= buf_idx + BUF_W'(1);
          cur_addr <= cur_addr + step;
        end
      end
    end
  end

endmodule

// File: rtl/dma_line_sched.sv
// dma_line_sched: turns sensor line_start pulses into DMA write commands over a DDR buffer ring.
// Latency: command valid the cycle after line_start; indexes/buf_irq visible the cycle after cmd_done.
// Backpressure: cmd_valid/cmd_addr held until cmd_ready; one extra line_start is buffered, further ones set overrun.
// Ports: clk, reset (async, active-high), enable, ring geometry (base_addr, line_bytes,
//        lines_per_buf, num_bufs), line_start, cmd_* write-command handshake, cmd_done,
//        dma_indexes status word, buf_irq, overrun, timeout_err.
// Optional: define DMA_LINE_SCHED_TIMEOUT_EN to add the cmd_done watchdog (TIMEOUT_CYCLES).
module dma_line_sched
  import dma_line_sched_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LEN_W          = LEN_W_DEF,
  parameter int LINE_W         = LINE_W_DEF,
  parameter int BUF_W          = BUF_W_DEF,
  parameter int FRAME_W        = FRAME_W_DEF,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [LEN_W-1:0]                  line_bytes,
  input  logic [LINE_W-1:0]                 lines_per_buf,
  input  logic [BUF_W-1:0]                  num_bufs,
  input  logic                              line_start,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [ADDR_W-1:0]                 cmd_addr,
  output logic [LEN_W-1:0]                  cmd_len,
  input  logic                              cmd_done,
  output logic [FRAME_W+BUF_W+LINE_W-1:0]   dma_indexes,
  output logic                              buf_irq,
  output logic                              overrun,
  output logic                              timeout_err
);

  sched_state_t state, state_n;

  logic               enable_q;
  logic               en_rise;
  logic               pending;
  logic               advance;
  logic               consume;
  logic               ls_set;
  logic               tmo_hit;
  logic               blocked;
  logic [LINE_W-1:0]  line_idx;
  logic [BUF_W-1:0]   buf_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic [ADDR_W-1:0]  cur_addr;
  logic               last_line;

  assign en_rise = enable & ~enable_q;

  // A line_start is buffered when the FSM is busy, or when a pending line is being
  // consumed this very cycle (so the pulse is not lost while pending hands over).
  assign ls_set = enable & line_start & ~blocked & ((state != IDLE) | pending);

  dma_ring_ptr #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .LINE_W  (LINE_W),
    .BUF_W   (BUF_W),
    .FRAME_W (FRAME_W)
  ) u_ptr (
    .clk           (clk),
    .rst           (reset),
    .init          (en_rise),
    .advance       (advance),
    .base_addr     (base_addr),
    .line_bytes    (line_bytes),
    .lines_per_buf (lines_per_buf),
    .num_bufs      (num_bufs),
    .line_idx      (line_idx),
    .buf_idx       (buf_idx),
    .frame_cnt     (frame_cnt),
    .cur_addr      (cur_addr),
    .last_line     (last_line)
  );

`ifdef DMA_LINE_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        blocked_q;
  logic        timeout_q;

  assign tmo_hit     = (state == WAIT_DONE) && !cmd_done && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign blocked     = blocked_q;
  assign timeout_err = timeout_q;

  // Counts cycles spent in WAIT_DONE; any other state restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      blocked_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 32'd1 : 32'd0;
      if (en_rise) begin
        blocked_q <= 1'b0;
        timeout_q <= 1'b0;
      end else if (tmo_hit) begin
        blocked_q <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign blocked     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    advance = 1'b0;
    consume = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !blocked && (line_start || pending)) begin
          state_n = ISSUE;
          consume = pending;
        end
      end
      ISSUE: begin
        // Deliberately ignores enable: a presented command is never withdrawn.
        if (cmd_ready) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (cmd_done) begin
          advance = 1'b1;
          if (enable && pending && !blocked) begin
            state_n = ISSUE;
            consume = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (tmo_hit) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      enable_q    <= 1'b0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      dma_indexes <= '0;
      buf_irq     <= 1'b0;
    end else begin
      state    <= state_n;
      enable_q <= enable;
      buf_irq  <= advance & last_line;
      if (advance) dma_indexes <= {frame_cnt, buf_idx, line_idx};

      if (en_rise) begin
        pending <= 1'b0;
        overrun <= 1'b0;
      end else if (!enable) begin
        pending <= 1'b0;  // a buffered line is discarded on disable
      end else begin
        if (tmo_hit)      pending <= 1'b0;
        else if (consume) pending <= ls_set;
        else              pending <= pending | ls_set;
        if ((ls_set && pending && !consume) || (line_start && blocked)) overrun <= 1'b1;
      end
    end
  end

  assign cmd_valid = (state == ISSUE);
  assign cmd_addr  = cur_addr;
  assign cmd_len   = line_bytes;

endmodule

// File: tb/tb_dma_line_sched.sv
module tb_dma_line_sched;
  import dma_line_sched_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [15:0] LB   = 16'h0800;

  logic        clk = 1'b0;
  logic        reset, enable, line_start, cmd_ready, cmd_done;
  logic [31:0] base_addr;
  logic [15:0] line_bytes;
  logic [11:0] lines_per_buf;
  logic [3:0]  num_bufs;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [28:0] dma_indexes;
  logic        buf_irq, overrun, timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_line_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .base_addr     (base_addr),
    .line_bytes    (line_bytes),
    .lines_per_buf (lines_per_buf),
    .num_bufs      (num_bufs),
    .line_start    (line_start),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_done      (cmd_done),
    .dma_indexes   (dma_indexes),
    .buf_irq       (buf_irq),
    .overrun       (overrun),
    .timeout_err   (timeout_err)
  );

  function automatic logic [28:0] mk_idx(input int f, input int b, input int l);
    dma_idx_t t;
    t.frame_cnt = 13'(f);
    t.buf_idx   = 4'(b);
    t.line_idx  = 12'(l);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Restart the ring from base with the standard test geometry.
  task automatic enable_cycle();
    enable = 1'b0;
    tick();
    base_addr     = BASE;
    line_bytes    = LB;
    lines_per_buf = 12'd4;
    num_bufs      = 4'd2;
    cmd_ready     = 1'b1;
    enable        = 1'b1;
    tick();
  endtask

  // One full line: line_start, accept the command, cmd_done 5 cycles later. Observes only.
  task automatic run_line(output logic [31:0] addr, output logic [15:0] len,
                          output logic irq, output logic [28:0] idx, output logic seen);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    addr = cmd_addr;
    len  = cmd_len;
    tick();
    repeat (3) tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    irq = buf_irq;
    idx = dma_indexes;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cmd_valid); end
    total++; if (dma_indexes !== 29'd0) begin bad++; $display("FAIL reset_idx got=%h want=0", dma_indexes); end
    total++; if (buf_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", buf_irq); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] a; logic [15:0] l; logic irq; logic [28:0] idx; logic seen;
    enable_cycle();
    run_line(a, l, irq, idx, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL basic_issue got=%b want=1", seen); end
    total++; if (a !== BASE) begin bad++; $display("FAIL basic_addr got=%h want=%h", a, BASE); end
    total++; if (l !== LB) begin bad++; $display("FAIL basic_len got=%h want=%h", l, LB); end
    total++; if (idx !== mk_idx(0, 0, 0)) begin bad++; $display("FAIL basic_idx got=%h want=0", idx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq got=%b want=0", irq); end
  endtask

  task automatic test_ring_wrap();
    logic [31:0] a, ea; logic [15:0] l; logic irq, eirq; logic [28:0] idx, eidx; logic seen;
    enable_cycle();
    for (int i = 0; i < 9; i++) begin
      run_line(a, l, irq, idx, seen);
      ea   = BASE + 32'((i % 8) * 32'h800);
      eirq = (i == 3) || (i == 7);
      eidx = mk_idx(i / 4, (i / 4) % 2, i % 4);
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL wrap_issue line=%0d got=%b want=1", i, seen); end
      total++; if (a !== ea) begin bad++; $display("FAIL wrap_addr line=%0d got=%h want=%h", i, a, ea); end
      total++; if (irq !== eirq) begin bad++; $display("FAIL wrap_irq line=%0d got=%b want=%b", i, irq, eirq); end
      total++; if (idx !== eidx) begin bad++; $display("FAIL wrap_idx line=%0d got=%h want=%h", i, idx, eidx); end
      if (i == 7) begin
        tick();
        total++; if (buf_irq !== 1'b0) begin bad++; $display("FAIL wrap_irq_pulse got=%b want=0", buf_irq); end
      end
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    enable_cycle();
    cmd_ready  = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, cmd_valid); end
      total++; if (cmd_addr !== BASE) begin bad++; $display("FAIL bp_addr cyc=%0d got=%h want=%h", i, cmd_addr, BASE); end
      if (cmd_valid && cmd_ready) hs++;
      tick();
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid && cmd_ready) hs++;
      tick();
    end
    total++; if (hs !== 1) begin bad++; $display("FAIL bp_handshakes got=%0d want=1", hs); end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  task automatic test_pending_overrun();
    enable_cycle();
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();  // accepted, now waiting for done
    line_start = 1'b1; tick(); line_start = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL pend_first got=%b want=0", overrun); end
    line_start = 1'b1; tick(); line_start = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL pend_overrun got=%b want=1", overrun); end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL pend_reissue got=%b want=1", cmd_valid); end
    total++; if (cmd_addr !== BASE + 32'h800) begin bad++; $display("FAIL pend_addr got=%h want=%h", cmd_addr, BASE + 32'h800); end
    tick(); tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (dma_indexes !== mk_idx(0, 0, 1)) begin bad++; $display("FAIL pend_idx got=%h want=%h", dma_indexes, mk_idx(0, 0, 1)); end
    tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL pend_dropped got=%b want=0", cmd_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL pend_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_consume_same_cycle();
    enable_cycle();
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    line_start = 1'b1; tick(); line_start = 1'b0;
    line_start = 1'b1; cmd_done = 1'b1; tick(); line_start = 1'b0; cmd_done = 1'b0;
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL same_reissue got=%b want=1", cmd_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL same_overrun got=%b want=0", overrun); end
    tick(); tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL same_third got=%b want=1", cmd_valid); end
    total++; if (cmd_addr !== BASE + 32'h1000) begin bad++; $display("FAIL same_addr got=%h want=%h", cmd_addr, BASE + 32'h1000); end
    tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL same_overrun_end got=%b want=0", overrun); end
  endtask

  task automatic test_disable();
    logic [31:0] a; logic [15:0] l; logic irq; logic [28:0] idx; logic seen;
    enable_cycle();
    run_line(a, l, irq, idx, seen);
    run_line(a, l, irq, idx, seen);
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    line_start = 1'b1; tick(); line_start = 1'b0;  // buffered, then discarded by disable
    enable = 1'b0;
    tick(); tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (dma_indexes !== mk_idx(0, 0, 2)) begin bad++; $display("FAIL dis_idx got=%h want=%h", dma_indexes, mk_idx(0, 0, 2)); end
    tick(); tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL dis_idle got=%b want=0", cmd_valid); end
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL dis_ls_ignored got=%b want=0", cmd_valid); end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    total++; if (dma_indexes !== mk_idx(0, 0, 2)) begin bad++; $display("FAIL stray_done_idx got=%h want=%h", dma_indexes, mk_idx(0, 0, 2)); end
    total++; if (buf_irq !== 1'b0) begin bad++; $display("FAIL stray_done_irq got=%b want=0", buf_irq); end
  endtask

  task automatic test_async_reset();
    enable_cycle();
    cmd_ready  = 1'b0;
    line_start = 1'b1; tick(); line_start = 1'b0;
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", cmd_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", cmd_valid); end
    total++; if (dma_indexes !== 29'd0) begin bad++; $display("FAIL ar_idx got=%h want=0", dma_indexes); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ar_overrun got=%b want=0", overrun); end
    tick();
    reset     = 1'b0;
    cmd_ready = 1'b1;
    enable    = 1'b0;
    tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL ar_after got=%b want=0", cmd_valid); end
  endtask

`ifdef DMA_LINE_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] a; logic [15:0] l; logic irq; logic [28:0] idx; logic seen;
    int n = 0;
    enable_cycle();
    run_line(a, l, irq, idx, seen);
    run_line(a, l, irq, idx, seen);
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();  // accepted; no cmd_done will follow
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (timeout_err) break;
    end
    total++; if (n !== 16) begin bad++; $display("FAIL tmo_cycles got=%0d want=16", n); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", timeout_err); end
    total++; if (dma_indexes !== mk_idx(0, 0, 1)) begin bad++; $display("FAIL tmo_idx got=%h want=%h", dma_indexes, mk_idx(0, 0, 1)); end
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL tmo_overrun got=%b want=1", overrun); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL tmo_blocked got=%b want=0", cmd_valid); end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; line_start = 1'b0; cmd_ready = 1'b1; cmd_done = 1'b0;
    base_addr = '0; line_bytes = '0; lines_per_buf = '0; num_bufs = '0;
    test_reset();
    test_basic();
    test_ring_wrap();
    test_backpressure();
    test_pending_overrun();
    test_consume_same_cycle();
    test_disable();
    test_async_reset();
`ifdef DMA_LINE_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
